// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
// Provides the depth derivation from ADDR_WIDTH, the pointer/count width
// helpers, the read-mode enumeration and the legality checks for the
// almost-full / almost-empty thresholds.
package fifo_pkg;

  typedef enum logic {
    READ_STANDARD = 1'b0,
    READ_FWFT     = 1'b1
  } read_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers wrap naturally over the address width.
  function automatic int ptr_width(input int addr_width);
    return addr_width;
  endfunction

  // The count needs one extra bit to represent DEPTH itself.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit af_thresh_legal(input int af_thresh, input int addr_width);
    return (af_thresh >= 1) && (af_thresh <= fifo_depth(addr_width));
  endfunction

  function automatic bit ae_thresh_legal(input int ae_thresh, input int addr_width);
    return (ae_thresh >= 0) && (ae_thresh <= fifo_depth(addr_width) - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a sync_fifo and its producer/consumer.
// master : the producer/consumer side (drives requests and write data)
// slave  : the FIFO side (drives read data, status flags, count, pulses)
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                                          write_ena;
  logic [DATA_WIDTH-1:0]                         write_data;
  logic                                          write_full;
  logic                                          write_almost_full;
  logic                                          read_ena;
  logic [DATA_WIDTH-1:0]                         read_data;
  logic                                          read_valid;
  logic                                          read_empty;
  logic                                          read_almost_empty;
  logic [fifo_pkg::count_width(ADDR_WIDTH)-1:0]  count;
  logic                                          overflow;
  logic                                          underflow;

  modport master (
    output write_ena, write_data, read_ena,
    input  write_full, write_almost_full, read_data, read_valid,
           read_empty, read_almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_ena, write_data, read_ena,
    output write_full, write_almost_full, read_data, read_valid,
           read_empty, read_almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port, one registered
// synchronous read port, DATA_WIDTH x (1<<ADDR_WIDTH).
// Ports: clk, rst (clears only the read register), wr_en/wr_addr/wr_data,
// rd_en/rd_addr, rd_data (updates on the edge after rd_en).
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset so it can map onto a
  // RAM macro; only the output register below is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller: pointers, occupancy count, full/empty and
// almost-full/almost-empty flags, overflow/underflow pulses, and an optional
// first-word-fall-through read mode.
// Ports: clk, rst (synchronous, active-high), bus (sync_fifo_if.slave).
// In FWFT mode the RAM's registered read port acts as the prefetch register:
// its contents are the head word whenever read_valid is high.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);
  localparam int         DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam int         PW        = ptr_width(ADDR_WIDTH);
  localparam int         CW        = count_width(ADDR_WIDTH);
  localparam read_mode_e READ_MODE = (FWFT != 0) ? READ_FWFT : READ_STANDARD;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  generate
    if (!af_thresh_legal(AF_THRESH, ADDR_WIDTH)) begin : g_bad_af
      $error("sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (!ae_thresh_legal(AE_THRESH, ADDR_WIDTH)) begin : g_bad_ae
      $error("sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_nxt, ram_words;
  logic                  full_q, almost_full_q, empty_q, almost_empty_q;
  logic                  valid_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc, ram_rd, ram_we, valid_nxt;
  logic [DATA_WIDTH-1:0] ram_q;

  // NOTE: every signal gets a value on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    // Acceptance looks only at the registered flags: no pass-through when
    // full or empty, even with a simultaneous request on the other side.
    wr_acc = bus.write_ena && !full_q;
    rd_acc = bus.read_ena && !empty_q;

    // Words still sitting in RAM (the head word, if held, is already out).
    ram_words = count_q - {{(CW-1){1'b0}}, valid_q};

    if (READ_MODE == READ_FWFT) begin
      // Refill the head whenever it is empty or being popped.
      ram_rd    = (!valid_q || rd_acc) && (ram_words != '0);
      valid_nxt = ram_rd || (valid_q && !rd_acc);
    end else begin
      ram_rd    = rd_acc;
      valid_nxt = rd_acc;
    end

    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_nxt = count_q - CNT_ONE;
  end

  assign ram_we = wr_acc && !rst;

  // NOTE: non-blocking assignments throughout, so every register here
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      valid_q        <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd) rd_ptr <= rd_ptr + PTR_ONE;
      count_q        <= count_nxt;
      // Flags are derived from the next count so they always agree with the
      // count displayed alongside them.
      full_q         <= (count_nxt == CNT_FULL);
      almost_full_q  <= (count_nxt >= AF_CNT);
      almost_empty_q <= (count_nxt <= AE_CNT);
      empty_q        <= (READ_MODE == READ_FWFT) ? !valid_nxt : (count_nxt == '0);
      valid_q        <= valid_nxt;
      overflow_q     <= bus.write_ena && full_q;
      underflow_q    <= bus.read_ena && empty_q;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (bus.write_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  assign bus.read_data         = ram_q;
  assign bus.read_valid        = valid_q;
  assign bus.read_empty        = empty_q;
  assign bus.read_almost_empty = almost_empty_q;
  assign bus.write_full        = full_q;
  assign bus.write_almost_full = almost_full_q;
  assign bus.count             = count_q;
  assign bus.overflow          = overflow_q;
  assign bus.underflow         = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. Two depth-4, 8-bit instances (standard
// and FWFT, AF_THRESH=3, AE_THRESH=1) receive identical stimulus; each is
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst;
  logic we, re;
  logic [DW-1:0] wd;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) std_if ();
  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fwft_if ();

  assign std_if.write_ena   = we;
  assign std_if.write_data  = wd;
  assign std_if.read_ena    = re;
  assign fwft_if.write_ena  = we;
  assign fwft_if.write_data = wd;
  assign fwft_if.read_ena   = re;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(std_if));
  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(fwft_if));

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Standard: plain queue. FWFT: queue entries carry the edge index at which
  // they were written; a word becomes the visible head one edge later.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  logic [DW-1:0] sq[$];
  logic [DW-1:0] s_rdata;
  bit            s_valid, s_ovf, s_unf;
  ent_t          fq[$];
  logic [DW-1:0] f_rdata;
  bit            f_valid, f_ovf, f_unf;
  int            cyc = 0;

  task automatic model_edge(input bit rs, input bit w, input logic [DW-1:0] d, input bit r);
    int   ssz;
    int   fsz;
    ent_t e;
    ssz = sq.size();
    fsz = fq.size();
    if (rs) begin
      sq.delete();
      fq.delete();
      s_rdata = '0; s_valid = 0; s_ovf = 0; s_unf = 0;
      f_rdata = '0; f_valid = 0; f_ovf = 0; f_unf = 0;
    end else begin
      s_ovf = w && (ssz == DEPTH);
      s_unf = r && (ssz == 0);
      s_valid = r && (ssz > 0);
      if (s_valid) s_rdata = sq.pop_front();
      if (w && ssz < DEPTH) sq.push_back(d);

      f_ovf = w && (fsz == DEPTH);
      f_unf = r && !f_valid;
      if (r && f_valid) void'(fq.pop_front());
      if (w && fsz < DEPTH) begin
        e.d = d;
        e.t = cyc;
        fq.push_back(e);
      end
      f_valid = (fq.size() > 0) && (fq[0].t <= cyc - 1);
      if (f_valid) f_rdata = fq[0].d;
    end
  endtask

  task automatic check_outputs();
    int sc;
    int fc;
    sc = sq.size();
    fc = fq.size();
    check("std_count", 32'(std_if.count), sc);
    check("std_flags",
          {std_if.write_full, std_if.write_almost_full, std_if.read_empty,
           std_if.read_almost_empty, std_if.read_valid, std_if.overflow, std_if.underflow},
          {sc == DEPTH, sc >= AF, sc == 0, sc <= AE, s_valid, s_ovf, s_unf});
    check("std_data", 32'(std_if.read_data), 32'(s_rdata));
    check("fwft_count", 32'(fwft_if.count), fc);
    check("fwft_flags",
          {fwft_if.write_full, fwft_if.write_almost_full, fwft_if.read_empty,
           fwft_if.read_almost_empty, fwft_if.read_valid, fwft_if.overflow, fwft_if.underflow},
          {fc == DEPTH, fc >= AF, !f_valid, fc <= AE, f_valid, f_ovf, f_unf});
    if (f_valid) check("fwft_head", 32'(fwft_if.read_data), 32'(f_rdata));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit rs);
    we  = w;
    wd  = d;
    re  = r;
    rst = rs;
    model_edge(rs, w, d, r);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  logic [DW-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  bit            ae_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit            af_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    we = 0; re = 0; wd = '0; rst = 1;

    // Reset then idle.
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    check("rst_count", 32'(std_if.count), 0);
    check("rst_empty", 32'(std_if.read_empty), 1);
    check("rst_aempty", 32'(std_if.read_almost_empty), 1);
    check("rst_rdata", 32'(std_if.read_data), 0);
    check("rst_fwft_valid", 32'(fwft_if.read_valid), 0);
    check("rst_fwft_rdata", 32'(fwft_if.read_data), 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);

    // Fill, overflow, drain in order, underflow.
    for (int i = 0; i < 4; i++) cycle(1, pat[i], 0, 0);
    check("fill_full", 32'(std_if.write_full), 1);
    check("fill_count", 32'(std_if.count), 4);
    cycle(1, 8'h55, 0, 0);
    check("ovf_pulse", 32'(std_if.overflow), 1);
    check("ovf_count", 32'(std_if.count), 4);
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      check("drain_data", 32'(std_if.read_data), 32'(pat[i]));
      check("drain_valid", 32'(std_if.read_valid), 1);
    end
    check("drain_empty", 32'(std_if.read_empty), 1);
    cycle(0, '0, 1, 0);
    check("unf_pulse", 32'(std_if.underflow), 1);

    // Simultaneous read+write at full and at empty.
    for (int i = 0; i < 4; i++) cycle(1, 8'h60 + 8'(i), 0, 0);
    cycle(1, 8'h66, 1, 0);
    check("rw_full_ovf", 32'(std_if.overflow), 1);
    check("rw_full_count", 32'(std_if.count), 3);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    cycle(1, 8'h77, 1, 0);
    check("rw_empty_unf", 32'(std_if.underflow), 1);
    check("rw_empty_count", 32'(std_if.count), 1);

    // Thresholds while filling from empty, then reset at count 3.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'h80 + 8'(i), 0, 0);
      check("thr_aempty", 32'(std_if.read_almost_empty), 32'(ae_exp[i + 1]));
      check("thr_afull", 32'(std_if.write_almost_full), 32'(af_exp[i + 1]));
    end
    cycle(0, '0, 0, 1);
    check("midrst_count", 32'(std_if.count), 0);
    check("midrst_empty", 32'(std_if.read_empty), 1);
    check("midrst_fwft_count", 32'(fwft_if.count), 0);

    // FWFT write-to-head latency, then a continuous pop of four words.
    cycle(1, 8'hA5, 0, 0);
    check("fwft_lat_n", 32'(fwft_if.read_valid), 0);
    cycle(0, '0, 0, 0);
    check("fwft_lat_n1_valid", 32'(fwft_if.read_valid), 1);
    check("fwft_lat_n1_data", 32'(fwft_if.read_data), 32'h A5);
    for (int i = 1; i < 4; i++) cycle(1, pat[i], 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("fwft_pop_valid", 32'(fwft_if.read_valid), 1);
      check("fwft_pop_data", 32'(fwft_if.read_data), (i == 0) ? 32'h A5 : 32'(pat[i]));
      cycle(0, '0, 1, 0);
    end
    check("fwft_pop_count", 32'(fwft_if.count), 0);

    // Wrap-around: interleaved write/read pairs through the depth-4 FIFO.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(i * 7 + 3), 0, 0);
      cycle(0, '0, 1, 0);
      check("wrap_data", 32'(std_if.read_data), 32'(8'(i * 7 + 3)));
    end

    // Randomized traffic with phase-varying bias and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int wb;
      int rb;
      wb = (i < 1000) ? 70 : ((i < 2000) ? 35 : 55);
      rb = (i < 1000) ? 35 : ((i < 2000) ? 70 : 55);
      cycle($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < rb,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the synchronous successor to the team's asynchronous FIFO RAM. It adds full pointer/flag control, an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between same-clock producer/consumer stages as the general-purpose buffering primitive.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 6, log2 depth; DEPTH = 1<<ADDR_WIDTH entries
- AF_THRESH, DEPTH-4, write_almost_full asserts when count >= AF_THRESH (legal 1..DEPTH)
- AE_THRESH, 4, read_almost_empty asserts when count <= AE_THRESH (legal 0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- write_ena  in  1  write request
- write_data  in  DATA_WIDTH  write word
- write_full  out  1  count == DEPTH
- write_almost_full  out  1  count >= AF_THRESH
- read_ena  in  1  read request (FWFT: pop)
- read_data  out  DATA_WIDTH  read word
- read_valid  out  1  standard: read_data updated this cycle; FWFT: read_data holds head word
- read_empty  out  1  standard: count == 0; FWFT: !read_valid
- read_almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  stored words, 0..DEPTH
- overflow  out  1  one-cycle pulse: write_ena while write_full
- underflow  out  1  one-cycle pulse: read_ena while read_empty

## Operation
- Write accepted iff write_ena && !write_full; word stored at write pointer, pointer increments mod DEPTH (natural wrap of ADDR_WIDTH bits).
- Read accepted iff read_ena && !read_empty. Flags evaluated on current-cycle state only; no pass-through: write is rejected when full even with a simultaneous read; read is rejected when empty even with a simultaneous write.
- Rejected requests change no state except the overflow/underflow pulse.
- count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither. In FWFT, count includes the word in the prefetch register; total capacity is DEPTH in both modes.
- Standard mode: accepted read loads read_data at the next edge; read_valid high for exactly that cycle. read_data holds its last value otherwise.
- FWFT mode: a prefetch register holds the head word. It loads from RAM whenever it is empty, or is being popped, and RAM holds data. read_valid stays high while a word is held; read_ena pops it.
- All status outputs are registered and mutually consistent: in any cycle, flags equal their definitions applied to the displayed count.
- Reset values: pointers 0, count 0, write_full 0, write_almost_full 0, read_empty 1, read_almost_empty 1, read_valid 0, read_data 0, overflow 0, underflow 0. RAM contents are not cleared.
- Reset mid-operation: all stored data is discarded; requests presented during a reset cycle are ignored and produce no pulses.

## Timing
- Write at edge N: count/flags update after N. Standard mode: read_empty low after N, so a read accepted at N+1 gives read_data after N+1.
- FWFT: a write into an empty FIFO at edge N gives read_valid high after edge N+1 (2-cycle write-to-head). Back-to-back pops sustain one word per cycle.
- Standard read latency: 1 cycle from accepted read_ena to read_data.
- Full throughput: one write plus one read per cycle, sustained.
- overflow/underflow assert in the cycle after the offending edge, for one cycle.

## Structure
- Shared package fifo_pkg holds the DEPTH derivation, the pointer/count width constants and the parameter legality checks (AF_THRESH/AE_THRESH range).
- One sub-module, sync_fifo_ram: simple dual-port RAM, DATA_WIDTH x DEPTH, write-enable gated, registered synchronous read port. The controller (pointers, count, flags, FWFT prefetch) lives in sync_fifo.

## Test plan
- Reset then idle: all outputs at the listed reset values; count=0, read_empty=1, read_almost_empty=1.
- DATA_WIDTH=8, ADDR_WIDTH=2, standard mode: write 0x11,0x22,0x33,0x44 -> write_full=1, count=4. Fifth write -> overflow pulse, count stays 4. Four reads -> 0x11..0x44 each 1 cycle after read_ena, then read_empty=1.
- Wrap-around, standard mode: 10 interleaved write/read pairs through a depth-4 FIFO -> data order preserved and count never exceeds 4.
- Simultaneous read+write: at count=4 -> write rejected, overflow=1, count 3. At count=0 -> read rejected, underflow=1, count 1.
- FWFT=1: write 0xA5 into empty FIFO at edge N -> read_valid=1 with read_data=0xA5 after N+1. Continuous pop of 4 words -> one per cycle.
- Thresholds AF_THRESH=3, AE_THRESH=1: count 0->1->2->3 gives almost_empty 1,1,0,0 and almost_full 0,0,0,1. Assert rst at count=3 -> next cycle count=0, read_empty=1.
